// File: rtl/clap_replay.sv
// clap_replay: stores up to DEPTH clap intervals and replays them as single-cycle pulses
module clap_replay #(
   parameter int CNT_W    = 17,
   parameter int MAXCOUNT = 66080,
   parameter int DEPTH    = 8,
   parameter int IDX_W    = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             wr_en,
   input  logic [CNT_W-1:0] wr_data,
   input  logic             clear,
   input  logic             go,
   input  logic             stop,
   input  logic             en,
   output logic             pulse,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] num_stored,
   output logic             full,
   output logic [CNT_W-1:0] remaining
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] PULSE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam int A_W = $clog2(DEPTH);
   logic [1:0]       state, state_nx;
   logic [IDX_W-1:0] idx, num_nx;
   logic [CNT_W-1:0] mem [DEPTH];
   logic             idle, abort, go_ok, do_wr, last;
   always_comb begin
      idle     = state == IDLE;
      abort    = !idle && stop;
      go_ok    = idle && !clear && go && num_stored != '0;
      do_wr    = idle && !clear && !go_ok && wr_en && !full;
      last     = idx == num_stored;
      num_nx   = (idle && clear) ? '0 : do_wr ? num_stored + 1'b1 : num_stored;
      state_nx = abort           ? IDLE :
                 idle            ? (go_ok ? PULSE : IDLE) :
                 (state == PULSE) ? (last ? IDLE : WAIT) :
                 (remaining == '0 ? PULSE : WAIT);
   end
   always_ff @(posedge clk)
      if (do_wr)
         mem[num_stored[A_W-1:0]] <= (wr_data > CNT_W'(MAXCOUNT)) ? CNT_W'(MAXCOUNT) : wr_data;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state      <= IDLE;
         idx        <= '0;
         num_stored <= '0;
         remaining  <= '0;
         pulse      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         full       <= 1'b0;
      end else begin
         state      <= state_nx;
         pulse      <= state_nx == PULSE;
         busy       <= state_nx != IDLE;
         done       <= state == PULSE && !stop && last;
         num_stored <= num_nx;
         full       <= num_nx == IDX_W'(DEPTH);
         if (go_ok)
            idx <= '0;
         else if (state == PULSE && !stop && !last)
            idx <= idx + 1'b1;
         if (abort)
            remaining <= '0;
         else if (state == PULSE && !last)
            remaining <= mem[idx[A_W-1:0]];
         else if (state == WAIT && remaining != '0 && en)
            remaining <= remaining - 1'b1;
      end
endmodule
